// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: 8x8 unsigned multiply built from four passes through an
// external combinational 4x4 multiplier core, with valid/ready on both sides.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      operand handshake, in_a/in_b 8-bit unsigned operands
//   mul_m/mul_q            nibbles driven to the 4x4 core (zero outside MUL)
//   mul_p                  8-bit combinational product returned by the core
//   out_valid/out_ready    result handshake, out_product = 16-bit product
//   busy                   high while multiplying or holding a result
module mult8_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [3:0]  mul_m,
    output logic [3:0]  mul_q,
    input  logic [7:0]  mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_product,
    output logic        busy
);

    localparam int unsigned OP_W   = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned STEP_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [3:0]          shamt;
    logic [PROD_W-1:0]   pp;

    // State, step counter, accumulator and held operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next-state, nibble selection and partial-product accumulation
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        mul_m   = '0;
        mul_q   = '0;
        shamt   = '0;
        pp      = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = in_a;
                    b_d    = in_b;
                    acc_d  = '0;
                    step_d = '0;
                    if (SKIP_ZERO && ((in_a == '0) || (in_b == '0))) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                // step bit0 picks the A nibble, bit1 the B nibble;
                // shift is 0,4,4,8 for steps 0..3
                mul_m  = step_q[0] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
                mul_q  = step_q[1] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];
                shamt  = {step_q[1] & step_q[0], step_q[1] ^ step_q[0], 2'b00};
                pp     = PROD_W'(mul_p) << shamt;
                acc_d  = acc_q + pp;
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(3)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake/status outputs decode directly from the state register
    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q == S_MUL) || (state_q == S_DONE);
    assign out_product = acc_q;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl: directed cases from the test plan
// plus randomized operand pairs checked against a plain-arithmetic model.
module tb_mult8_seq_ctrl;

    logic        clk;
    logic        rst_n;

    // Main instance, zero skip enabled
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  in_a, in_b, mul_p;
    logic [3:0]  mul_m, mul_q;
    logic [15:0] out_product;

    // Second instance, zero skip disabled
    logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
    logic [7:0]  z_in_a, z_in_b, z_mul_p;
    logic [3:0]  z_mul_m, z_mul_q;
    logic [15:0] z_out_product;

    int checks = 0;
    int errors = 0;

    mult8_seq_ctrl #(.SKIP_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_m(mul_m), .mul_q(mul_q), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .busy(busy)
    );

    mult8_seq_ctrl #(.SKIP_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_a(z_in_a), .in_b(z_in_b),
        .mul_m(z_mul_m), .mul_q(z_mul_q), .mul_p(z_mul_p),
        .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_product(z_out_product), .busy(z_busy)
    );

    // Behavioural 4x4 cores
    assign mul_p   = {4'b0, mul_m} * {4'b0, mul_q};
    assign z_mul_p = {4'b0, z_mul_m} * {4'b0, z_mul_q};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Expected {m,q} nibble pair for step s: A nibble alternates low/high,
    // B nibble is low for the first two steps and high for the last two.
    function automatic logic [7:0] exp_pair(input int a, input int b, input int s);
        int m, q;
        m = (s % 2 == 0) ? (a % 16) : (a / 16);
        q = (s < 2) ? (b % 16) : (b / 16);
        return 8'((m * 16) + q);
    endfunction

    // Present a pair at a falling edge and hold it through the accept edge,
    // then scramble the operand inputs (must have no effect).
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
    endtask

    // Follow one transaction after its accept edge. k counts falling edges
    // after accept: out_valid rises on edge E4 (seen at k=5) or, for a
    // skipped zero operand, on the accept edge itself (seen at k=1).
    task automatic collect(input logic [7:0] a, input logic [7:0] b, input int hold,
                           input string tag);
        int  k;
        bit  skip;
        logic [15:0] prod;
        skip = (a == 0) || (b == 0);
        prod = 16'(int'(a) * int'(b));
        out_ready = (hold == 0);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (out_valid) break;
            if (k <= 4) chk({tag, "_mulpair"}, 32'({mul_m, mul_q}), 32'(exp_pair(a, b, k - 1)));
        end
        chk({tag, "_latency"}, 32'(k), skip ? 32'd1 : 32'd5);
        chk({tag, "_product"}, 32'(out_product), 32'(prod));
        chk({tag, "_idle_nibbles"}, 32'({mul_m, mul_q}), 32'd0);
        chk({tag, "_busy_in_ready"}, 32'({busy, in_ready}), 32'b10);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold"}, 32'({out_valid, out_product}), 32'({1'b1, prod}));
        end
        out_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] ra, rb;
        int k;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        z_in_valid = 1'b0; z_in_a = '0; z_in_b = '0; z_out_ready = 1'b1;

        // Reset values
        #1;
        chk("rst_outputs", 32'({in_ready, out_valid, busy}), 32'b100);
        chk("rst_product", 32'(out_product), 32'h0);
        chk("rst_nibbles", 32'({mul_m, mul_q}), 32'h0);
        chk("rst_nz_outputs", 32'({z_in_ready, z_out_valid, z_busy}), 32'b100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed: basic, max operands, zero skip
        issue(8'h12, 8'h34); collect(8'h12, 8'h34, 0, "basic");
        chk("basic_value", 32'(out_product), 32'h03A8);
        issue(8'hFF, 8'hFF); collect(8'hFF, 8'hFF, 0, "max");
        chk("max_value", 32'(out_product), 32'hFE01);
        issue(8'h00, 8'h5A); collect(8'h00, 8'h5A, 0, "zskip");

        // Zero operand with skipping disabled takes the full four steps
        @(negedge clk);
        z_in_valid = 1'b1; z_in_a = 8'h00; z_in_b = 8'h5A;
        @(posedge clk);
        #1 z_in_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (z_out_valid) break;
        end
        chk("nz_latency", 32'(k), 32'd5);
        chk("nz_product", 32'(z_out_product), 32'h0);

        // Backpressure with an ignored pair presented while busy
        out_ready = 1'b0;
        issue(8'h0F, 8'h0F);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (out_valid) break;
        end
        chk("bp_latency", 32'(k), 32'd5);
        in_valid = 1'b1; in_a = 8'h22; in_b = 8'h33;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("bp_hold", 32'({out_valid, in_ready, out_product}), 32'({2'b10, 16'h00E1}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_handoff", 32'({in_ready, out_valid}), 32'b10);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
        collect(8'h22, 8'h33, 0, "bp_second");
        chk("bp_second_value", 32'(out_product), 32'h06C6);

        // Reset asserted during step 2
        issue(8'hAB, 8'hCD);
        repeat (3) @(negedge clk);
        chk("mid_step2_pair", 32'({mul_m, mul_q}), 32'(exp_pair(8'hAB, 8'hCD, 2)));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", 32'({in_ready, out_valid, busy}), 32'b100);
        chk("mid_rst_product", 32'(out_product), 32'h0);
        chk("mid_rst_nibbles", 32'({mul_m, mul_q}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int h = 0; h < 6; h++) begin
            @(negedge clk);
            chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
        end
        issue(8'h03, 8'h05); collect(8'h03, 8'h05, 0, "post_rst");
        chk("post_rst_value", 32'(out_product), 32'h000F);

        // Randomized pairs with occasional zero operands and output stalls
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            issue(ra, rb);
            collect(ra, rb, int'($urandom_range(0, 3)), "rand");
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
